// File: rtl/dsp_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a 2-entry
// instruction queue, with branch redirect that flushes queue and in-flight data.
module dsp_fetch #(
   parameter int                 ADDR_W   = 16,
   parameter int                 INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               jump_flag,
   input  logic [ADDR_W-1:0]  jump_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   pc_r, pc_s;
   logic [ADDR_W-1:0]   req_pc_r, req_pc_s;
   logic                drop_r, drop_s;
   logic [1:0]          count_r, count_s;
   logic [1:0]          count_push_s;
   logic                push_s;
   logic                pop_s;
   logic                rd_ptr_r;
   logic                wr_ptr_r;
   logic [INSTR_W-1:0]  fifo_instr_r [2];
   logic [ADDR_W-1:0]   fifo_pc_r    [2];

   assign imem_req    = (state_r == ST_REQ);
   assign imem_addr   = pc_r;
   assign instr_valid = (count_r != 2'd0) && !jump_flag;
   assign instr       = fifo_instr_r[rd_ptr_r];
   assign instr_pc    = fifo_pc_r[rd_ptr_r];

   // Next-state, pc, drop and queue-count decisions for the fetch FSM.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      req_pc_s     = req_pc_r;
      drop_s       = drop_r;
      push_s       = 1'b0;
      pop_s        = instr_valid && instr_ready;
      count_push_s = count_r + 2'd1 - {1'b0, pop_s};

      case (state_r)
         ST_IDLE: begin
            if (jump_flag) begin
               state_s = ST_REQ;
               pc_s    = jump_addr;
            end else if (count_r < 2'd2) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (imem_gnt) begin
               state_s  = ST_WAIT;
               req_pc_s = pc_r;
               // A redirect coinciding with the grant still leaves one response to swallow.
               if (jump_flag) begin
                  pc_s   = jump_addr;
                  drop_s = 1'b1;
               end else begin
                  pc_s   = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  drop_s = 1'b0;
               end
            end else if (jump_flag) begin
               pc_s = jump_addr;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               drop_s = 1'b0;
               if (jump_flag) begin
                  pc_s    = jump_addr;
                  state_s = ST_REQ;
               end else if (drop_r) begin
                  state_s = ST_REQ;
               end else begin
                  push_s  = 1'b1;
                  state_s = (count_push_s < 2'd2) ? ST_REQ : ST_IDLE;
               end
            end else if (jump_flag) begin
               pc_s   = jump_addr;
               drop_s = 1'b1;
            end else begin
               state_s = ST_WAIT;
            end
         end
         default: begin
            state_s = ST_IDLE;
            drop_s  = 1'b0;
         end
      endcase

      if (jump_flag) begin
         count_s = 2'd0;
      end else begin
         count_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
      end
   end

   // FSM, pc and transaction-tracking registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         pc_r     <= RESET_PC;
         req_pc_r <= '0;
         drop_r   <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         state_r  <= state_s;
         pc_r     <= pc_s;
         req_pc_r <= req_pc_s;
         drop_r   <= drop_s;
         count_r  <= count_s;
      end
   end

   // Queue storage and pointers; a redirect realigns the head with the tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r        <= 1'b0;
         wr_ptr_r        <= 1'b0;
         fifo_instr_r[0] <= '0;
         fifo_instr_r[1] <= '0;
         fifo_pc_r[0]    <= '0;
         fifo_pc_r[1]    <= '0;
      end else begin
         if (jump_flag) begin
            rd_ptr_r <= wr_ptr_r;
         end else if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= imem_rdata;
            fifo_pc_r[wr_ptr_r]    <= req_pc_r;
            wr_ptr_r               <= ~wr_ptr_r;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
      end
   end

endmodule

// File: tb/tb_dsp_fetch.sv
// Scoreboard bench for dsp_fetch: a memory responder with random grant/latency,
// an expected instruction stream model (sequential pc, restarted by jumps), and a monitor.
module tb_dsp_fetch;

   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk;
   logic        rst_n;
   logic        jump_flag;
   logic [15:0] jump_addr;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [15:0] instr_pc;
   logic        instr_ready;

   dsp_fetch #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .jump_flag(jump_flag), .jump_addr(jump_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] exp_q [$];
   int          acc_count = 0;
   logic [15:0] last_pc   = 16'h0000;
   bit          seen_zero = 1'b0;

   int          gnt_pct  = 100;
   int          lat_min  = 1;
   int          lat_max  = 1;
   int          spur_pct = 0;
   bit          gnt_en   = 1'b1;
   bit          stale_mode = 1'b0;
   bit          pend_valid = 1'b0;
   logic [15:0] pend_addr  = 16'h0000;
   int          pend_cnt   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a ^ 16'hA5C3, ~a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Model: after a redirect or reset, decode sees addresses start, start+1, ... (mod 2^16).
   task automatic set_stream(input logic [15:0] start);
      exp_q.delete();
      for (int i = 0; i < 600; i++) exp_q.push_back(start + 16'(i));
   endtask

   task automatic wait_acc(input int n, input string name);
      int start_cnt;
      int k;
      start_cnt = acc_count;
      k = 0;
      while (acc_count < start_cnt + n && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(acc_count >= start_cnt + n), 64'd1);
   endtask

   task automatic wait_grant();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (!(imem_req && imem_gnt) && k < 100);
      chk("grant_seen", 64'(imem_req && imem_gnt), 64'd1);
   endtask

   // Memory responder: one pending read, random grant and latency, spurious rvalid when idle.
   initial begin
      bit had_pend;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         had_pend    = pend_valid;
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pend_valid) begin
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_addr);
               pend_valid  = 1'b0;
            end else begin
               pend_cnt--;
            end
         end else if (int'($urandom_range(99, 0)) < spur_pct) begin
            imem_rvalid = 1'b1;
         end
         imem_gnt = gnt_en && (int'($urandom_range(99, 0)) < gnt_pct);
         if (rst_n && imem_req && !stale_mode)
            chk("single_outstanding", 64'(had_pend), 64'd0);
         if (rst_n && imem_req && imem_gnt) begin
            pend_valid = 1'b1;
            pend_addr  = imem_addr;
            pend_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
         end
      end
   end

   // Monitor: pops the expected stream on every accepted instruction and checks request hold.
   initial begin
      logic        prev_hold;
      logic [15:0] prev_addr;
      logic [15:0] e;
      prev_hold = 1'b0;
      prev_addr = 16'h0000;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (jump_flag) chk("valid_low_on_jump", 64'(instr_valid), 64'd0);
            if (instr_valid && instr_ready) begin
               if (exp_q.size() == 0) begin
                  chk("stream_nonempty", 64'd0, 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("instr_pc", 64'(instr_pc), 64'(e));
                  chk("instr_word", 64'(instr), 64'(mem_word(e)));
                  acc_count++;
                  last_pc = instr_pc;
                  if (instr_pc == 16'h0000) seen_zero = 1'b1;
               end
            end
            if (prev_hold) begin
               chk("addr_hold_req", 64'(imem_req), 64'd1);
               chk("addr_hold_addr", 64'(imem_addr), 64'(prev_addr));
            end
         end
         prev_hold = rst_n && imem_req && !imem_gnt && !jump_flag;
         prev_addr = imem_addr;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"},   64'(imem_req),    64'd0);
      chk({tag, "_addr"},  64'(imem_addr),   64'(RST_PC));
      chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
      chk({tag, "_instr"}, 64'(instr),       64'd0);
      chk({tag, "_pc"},    64'(instr_pc),    64'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      set_stream(RST_PC);
      #1 chk("req_low_at_release", 64'(imem_req), 64'd0);
      @(negedge clk);
      #1;
      chk("req_one_cycle_after", 64'(imem_req), 64'd1);
      chk("first_fetch_addr", 64'(imem_addr), 64'(RST_PC));
   endtask

   // Stimulus: directed scenarios followed by a randomized run.
   initial begin
      int k;
      rst_n       = 1'b0;
      jump_flag   = 1'b0;
      jump_addr   = 16'h0000;
      instr_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("reset");

      // Back-to-back fetch with 1-cycle memory: one instruction every 2 cycles.
      release_reset();
      repeat (11) @(negedge clk);
      chk("throughput_4_in_12", 64'(acc_count >= 3 + 1), 64'd1);

      // Decode stall: queue fills to two entries and fetching stops.
      @(negedge clk);
      instr_ready = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("stall_req_low", 64'(imem_req), 64'd0);
      chk("stall_valid", 64'(instr_valid), 64'd1);

      // Redirect with a full queue.
      @(negedge clk);
      jump_flag = 1'b1;
      jump_addr = 16'h0100;
      set_stream(16'h0100);
      #1 chk("full_jump_valid_low", 64'(instr_valid), 64'd0);
      @(negedge clk);
      jump_flag = 1'b0;
      jump_addr = 16'h5555;
      #1;
      chk("full_jump_flushed", 64'(instr_valid), 64'd0);
      chk("full_jump_req", 64'(imem_req), 64'd1);
      chk("full_jump_addr", 64'(imem_addr), 64'h0100);
      instr_ready = 1'b1;
      wait_acc(2, "after_full_jump");

      // Redirect while a read is in flight: its data must be dropped.
      lat_min = 3;
      lat_max = 3;
      wait_grant();
      @(negedge clk);
      jump_flag = 1'b1;
      jump_addr = 16'h0040;
      set_stream(16'h0040);
      @(negedge clk);
      jump_flag = 1'b0;
      wait_acc(2, "after_wait_jump");
      chk("wait_jump_last_pc", 64'(last_pc), 64'h0041);

      // Address wraps from 0xFFFF to 0x0000.
      lat_min = 1;
      lat_max = 1;
      seen_zero = 1'b0;
      @(negedge clk);
      jump_flag = 1'b1;
      jump_addr = 16'hFFFE;
      set_stream(16'hFFFE);
      @(negedge clk);
      jump_flag = 1'b0;
      wait_acc(3, "wrap_progress");
      chk("wrap_to_zero", 64'(seen_zero), 64'd1);

      // Reset during WAIT: late response must be ignored, fetch restarts at RESET_PC.
      lat_min = 6;
      lat_max = 6;
      wait_grant();
      @(negedge clk);
      gnt_en     = 1'b0;
      stale_mode = 1'b1;
      rst_n      = 1'b0;
      exp_q.delete();
      #1 check_reset_outputs("async_reset");
      repeat (2) @(negedge clk);
      release_reset();
      k = 0;
      while (pend_valid && k < 20) begin
         @(negedge clk);
         #1 chk("stale_valid_low", 64'(instr_valid), 64'd0);
         k++;
      end
      @(negedge clk);
      #1 chk("stale_ignored", 64'(instr_valid), 64'd0);
      stale_mode = 1'b0;
      lat_min    = 1;
      lat_max    = 1;
      gnt_en     = 1'b1;
      wait_acc(2, "after_reset_restart");

      // Randomized traffic: random grant, latency, ready, spurious rvalid and redirects.
      gnt_pct  = 60;
      lat_min  = 1;
      lat_max  = 4;
      spur_pct = 20;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         instr_ready = (int'($urandom_range(99, 0)) < 75);
         if (int'($urandom_range(99, 0)) < 4) begin
            jump_flag = 1'b1;
            jump_addr = ($urandom_range(9, 0) == 0) ? 16'hFFFD : 16'($urandom);
            set_stream(jump_addr);
         end else begin
            jump_flag = 1'b0;
            jump_addr = 16'($urandom);
         end
      end
      @(negedge clk);
      jump_flag   = 1'b0;
      instr_ready = 1'b1;
      wait_acc(2, "random_tail");
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dsp_fetch.md
DSP_FETCH -- requirements
Module: dsp_fetch

Interface
REQ-001 Parameter ADDR_W, 16, instruction address width.
REQ-002 Parameter INSTR_W, 32, instruction word width.
REQ-003 Parameter RESET_PC, 0, first fetch address after reset.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 jump_flag  input  1  redirect request from branch unit.
REQ-007 jump_addr  input  ADDR_W  redirect target, meaningful only when jump_flag=1.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  ADDR_W  read address.
REQ-010 imem_gnt  input  1  memory accepts request this cycle.
REQ-011 imem_rvalid  input  1  read data valid, one pulse per granted request, latency >=1 cycle.
REQ-012 imem_rdata  input  INSTR_W  read data.
REQ-013 instr_valid  output  1  instruction available to decode.
REQ-014 instr  output  INSTR_W  instruction word at queue head.
REQ-015 instr_pc  output  ADDR_W  address of instr.
REQ-016 instr_ready  input  1  decode accepts head this cycle.

Function
REQ-017 FSM states IDLE, REQ, WAIT; at most one memory request outstanding.
REQ-018 imem_req = (state==REQ); imem_addr = pc register.
REQ-019 IDLE -> REQ when queue count<2 and jump_flag=0.
REQ-020 REQ & imem_gnt -> WAIT; req_pc<=pc; pc<=pc+1 modulo 2^ADDR_W (wrap silently).
REQ-021 imem_addr SHALL be held stable while imem_req=1 and imem_gnt=0, except on redirect.
REQ-022 WAIT & imem_rvalid & drop=0 -> push {imem_rdata, req_pc} into 2-entry FIFO; next state REQ if next count<2, else IDLE.
REQ-023 imem_rvalid outside WAIT SHALL be ignored.
REQ-024 FIFO: instr/instr_pc from head; instr_valid = (count!=0) & !jump_flag; pop on instr_valid & instr_ready; push and pop in same cycle keep count.
REQ-025 Push into a full FIFO SHALL never occur (issue gated by count<2, count cannot grow while request outstanding).
REQ-026 Redirect (jump_flag=1 at edge) has highest priority: pc<=jump_addr; FIFO count<=0; same-cycle push discarded.
REQ-027 Redirect in IDLE or REQ without gnt -> REQ with new pc.
REQ-028 Redirect in REQ with gnt, or in WAIT without rvalid -> WAIT with drop<=1.
REQ-029 Redirect in WAIT with rvalid -> data discarded, -> REQ, drop<=0.
REQ-030 WAIT & imem_rvalid & drop=1 -> data discarded, drop<=0, -> REQ.
REQ-031 Consecutive redirect cycles: last jump_addr wins.
REQ-032 Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency and instr_ready=1.

Reset
REQ-033 rst_n=0 asynchronously forces state IDLE, pc=RESET_PC, req_pc=0, drop=0, FIFO count=0, FIFO storage 0.
REQ-034 Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-035 Reset mid-request abandons outstanding transaction; first imem_req rises one cycle after rst_n deasserts.

Verification
REQ-036 Release reset, gnt=1, rvalid 1 cycle after gnt, ready=1 -> instr_pc sequence 0,1,2,3 with matching rdata, no gaps beyond 1 bubble each.
REQ-037 ready=0 for 10 cycles -> exactly 2 instructions queued, imem_req=0, no data lost; ready=1 drains them in order 0,1.
REQ-038 jump_flag=1, jump_addr=0x0040 while in WAIT -> pending rdata discarded, next instr_pc=0x0040, then 0x0041.
REQ-039 jump with FIFO full -> instr_valid=0 during jump cycle, FIFO empty after, next fetch address = jump_addr.
REQ-040 pc=0xFFFF, ADDR_W=16 -> next fetch address 0x0000.
REQ-041 Assert rst_n=0 during WAIT, later rvalid=1 -> response ignored, instr_valid stays 0, fetch restarts at RESET_PC.
